load_use_scoreboard: RTL and testbench

//  Next-gen pipeline hazard unit: per-register countdown scoreboard for loads with

---
 rtl/load_use_scoreboard_pkg.sv | 20 ++
 rtl/load_use_scoreboard_sb_counter.sv | 29 ++
 rtl/load_use_scoreboard.sv | 100 ++++++++++
 tb/tb_load_use_scoreboard.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/load_use_scoreboard_pkg.sv
// Shared constants and types for the load-use scoreboard hazard unit.
package load_use_scoreboard_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int LOAD_LAT_DEF   = 2;
    localparam int CNT_W_DEF      = 3;
    localparam int PERF_W_DEF     = 16;

    // Canonical NOP (addi x0,x0,0) injected by the pipe on bubble/flush.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Which hazard wins this cycle; encoded in priority order.
    typedef enum logic [1:0] {
        HZ_NONE    = 2'd0,
        HZ_LUSE    = 2'd1,
        HZ_BRANCH  = 2'd2,
        HZ_MEMWAIT = 2'd3
    } hz_sel_e;

endpackage

// File: rtl/load_use_scoreboard_sb_counter.sv
// Per-register load countdown: reloads on a load issue, otherwise counts to 0.
module sb_counter #(
    parameter int CNT_W    = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_set,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Reload wins over decrement; whole counter frozen while the pipe waits on memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_set)
                r_cnt <= CNT_W'(LOAD_LAT);
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit: per-register countdown scoreboard, hold/bubble/flush/freeze
// priority logic and a saturating stall-cycle performance counter.
module load_use_scoreboard
    import load_use_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int LOAD_LAT   = LOAD_LAT_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int PERF_W     = PERF_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_valid,
    input  logic                  id_is_load,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    output logic                  hold_pc,
    output logic                  hold_if_id,
    output logic                  bubble_id_ex,
    output logic                  flush_if_id,
    output logic                  freeze_all,
    output logic                  id_issue,
    output logic [PERF_W-1:0]     stall_count
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
    logic                           w_luse;
    logic                           w_set_load;
    hz_sel_e                        w_sel;
    logic [PERF_W-1:0]              r_stall_count;

    // x0 is never a real destination, so its entry is a constant zero.
    assign w_cnt[0] = '0;

    assign w_set_load = id_issue & id_is_load & (id_rd != '0);

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
            sb_counter #(
                .CNT_W    (CNT_W),
                .LOAD_LAT (LOAD_LAT)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .i_en  (~mem_busy),
                .i_set (w_set_load & (id_rd == REG_ADDR_W'(r))),
                .o_cnt (w_cnt[r])
            );
        end
    endgenerate

    assign w_luse = id_valid & ((id_use_rs1 & (w_cnt[id_rs1] != '0)) |
                                (id_use_rs2 & (w_cnt[id_rs2] != '0)));

    // Hazard selection and pipe controls: memory wait > taken branch > load-use.
    always_comb begin
        w_sel        = HZ_NONE;
        hold_pc      = 1'b0;
        hold_if_id   = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        freeze_all   = 1'b0;
        id_issue     = 1'b0;
        if (mem_busy) begin
            w_sel      = HZ_MEMWAIT;
            freeze_all = 1'b1;
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
        end else if (ex_branch_taken) begin
            w_sel        = HZ_BRANCH;
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (w_luse) begin
            w_sel        = HZ_LUSE;
            hold_pc      = 1'b1;
            hold_if_id   = 1'b1;
            bubble_id_ex = 1'b1;
        end else begin
            id_issue = id_valid;
        end
    end

    // Count load-use stall cycles only, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_count <= '0;
        else if ((w_sel == HZ_LUSE) && (r_stall_count != '1))
            r_stall_count <= r_stall_count + PERF_W'(1);
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench: directed hazard scenarios plus random traffic, both checked
// against a ready-time model of register availability.
module tb_load_use_scoreboard;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_valid, id_is_load, ex_branch_taken, mem_busy;
    logic       hold_pc, hold_if_id, bubble_id_ex, flush_if_id, freeze_all, id_issue;
    logic [15:0] stall_count;
    logic       s_hold_pc, s_hold_if_id, s_bubble, s_flush, s_freeze, s_issue;
    logic [1:0] s_stall_count;

    int ncmp = 0;
    int nfail = 0;

    // Model: a register is ready once the count of unfrozen edges reaches avail[r].
    longint t;
    longint avail [32];
    longint stalls;

    always #5 clk = ~clk;

    load_use_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_valid(id_valid),
        .id_is_load(id_is_load), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .hold_pc(hold_pc), .hold_if_id(hold_if_id),
        .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id), .freeze_all(freeze_all),
        .id_issue(id_issue), .stall_count(stall_count)
    );

    load_use_scoreboard #(.PERF_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_valid(id_valid),
        .id_is_load(id_is_load), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .hold_pc(s_hold_pc), .hold_if_id(s_hold_if_id),
        .bubble_id_ex(s_bubble), .flush_if_id(s_flush), .freeze_all(s_freeze),
        .id_issue(s_issue), .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        stalls = 0;
        for (int r = 0; r < 32; r++) avail[r] = 0;
    endtask

    // Drive one cycle of ID-stage inputs, check all outputs, advance the model.
    task automatic step(input logic v, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic br, input logic busy);
        logic hz, e_hold, e_bub, e_flush, e_frz, e_iss;
        longint sat16, sat2;
        @(negedge clk);
        id_valid = v; id_is_load = ld; id_rd = rd;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_branch_taken = br; mem_busy = busy;
        #1;
        hz = v && ((u1 && avail[rs1] > t) || (u2 && avail[rs2] > t));
        e_hold = 0; e_bub = 0; e_flush = 0; e_frz = 0; e_iss = 0;
        if (busy) begin
            e_frz = 1; e_hold = 1;
        end else if (br) begin
            e_flush = 1; e_bub = 1;
        end else if (hz) begin
            e_hold = 1; e_bub = 1;
        end else begin
            e_iss = v;
        end
        sat16 = (stalls > 65535) ? 65535 : stalls;
        sat2  = (stalls > 3) ? 3 : stalls;
        chk("hold_pc", hold_pc, e_hold);
        chk("hold_if_id", hold_if_id, e_hold);
        chk("bubble_id_ex", bubble_id_ex, e_bub);
        chk("flush_if_id", flush_if_id, e_flush);
        chk("freeze_all", freeze_all, e_frz);
        chk("id_issue", id_issue, e_iss);
        chk("stall_count", stall_count, 32'(sat16));
        chk("stall_count_sat", s_stall_count, 32'(sat2));
        if (!busy) begin
            if (!br && hz) stalls++;
            t++;
            if (e_iss && ld && rd != 0) avail[rd] = t + LAT;
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        id_valid = 0; id_is_load = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_branch_taken = 0; mem_busy = 0;
        #2;
        chk("rst_outputs", {hold_pc, hold_if_id, bubble_id_ex, flush_if_id, freeze_all, id_issue}, 0);
        chk("rst_stall_count", stall_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // load x5 then dependent: two stall cycles, issue on the third
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 0, 6, 5, 1, 0, 0, 0, 0);
        chk("x5_bubble1", bubble_id_ex, 1);
        step(1, 0, 6, 5, 1, 0, 0, 0, 0);
        chk("x5_bubble2", bubble_id_ex, 1);
        step(1, 0, 6, 5, 1, 0, 0, 0, 0);
        chk("x5_issue", id_issue, 1);
        chk("x5_stall_count", stall_count, 2);

        // load to x0 never creates a hazard
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 1, 0, 0);
        chk("x0_issue", id_issue, 1);

        // load x7, dependent frozen by memory wait, then normal stall resumes
        step(1, 1, 7, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8, 0, 0, 7, 1, 0, 1);
            chk("x7_freeze", freeze_all, 1);
        end
        chk("x7_count_held", stall_count, 2);
        step(1, 0, 8, 0, 0, 7, 1, 0, 0);
        chk("x7_bubble1", bubble_id_ex, 1);
        step(1, 0, 8, 0, 0, 7, 1, 0, 0);
        chk("x7_bubble2", bubble_id_ex, 1);
        step(1, 0, 8, 0, 0, 7, 1, 0, 0);
        chk("x7_issue", id_issue, 1);
        chk("sat_reached", s_stall_count, 3);

        // dependent on x9 while a taken branch resolves: flush wins
        step(1, 1, 9, 0, 0, 0, 0, 0, 0);
        step(1, 0, 2, 9, 1, 0, 0, 1, 0);
        chk("br_flush", flush_if_id, 1);
        chk("br_hold_pc", hold_pc, 0);
        step(1, 0, 2, 0, 0, 0, 0, 0, 0);
        chk("br_no_count", stall_count, 4);

        // back-to-back loads to x3: second issue reloads full latency
        step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 0, 4, 3, 1, 0, 0, 0, 0);
        chk("x3_bubble1", bubble_id_ex, 1);
        step(1, 0, 4, 3, 1, 0, 0, 0, 0);
        chk("x3_bubble2", bubble_id_ex, 1);
        step(1, 0, 4, 3, 1, 0, 0, 0, 0);
        chk("x3_issue", id_issue, 1);

        // random traffic on a small register window to keep hazards frequent
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 7) == 0));
        end

        // asynchronous reset between edges clears counters and scoreboard
        step(1, 1, 4, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        id_valid = 0; id_is_load = 0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", stall_count, 0);
        chk("async_rst_count_sat", s_stall_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 5, 4, 1, 0, 0, 0, 0);
        chk("post_rst_issue", id_issue, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
